// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants and types for the sequence-detector scheduler.
//   BYTE_W       - width of one requester byte
//   DEF_PAT_LEN  - default detected pattern length
//   DEF_PATTERN  - default pattern, first-received bit in MSB
//   sched_state_e - scheduler FSM states
package seq_det_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned DEF_PAT_LEN = 4;
  localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 4'b1101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    RESULT = 2'd3
  } sched_state_e;

endpackage

// File: rtl/pattern_det_core.sv
// pattern_det_core: non-overlapping Moore pattern detector.
// Ports:
//   clk        in  clock, posedge
//   reset      in  synchronous active-high reset
//   clr        in  return to the empty-prefix state (frame start)
//   en         in  advance the detector by one bit
//   bit_in     in  serial input bit
//   match_next out high when this enabled bit completes the pattern
module pattern_det_core
  import seq_det_pkg::*;
#(
  parameter int unsigned           PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0]    PATTERN = DEF_PATTERN
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic match_next
);

  localparam int unsigned LEN_W = $clog2(PAT_LEN);

  // State is the bits received since the last clear or match plus how many
  // of them are valid; equivalent to the prefix automaton for a fixed-length
  // pattern, and a match empties it so no bit is reused.
  logic [PAT_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [PAT_LEN-1:0] window;
  logic               full;

  assign window     = {hist_q, bit_in};
  assign full       = (fill_q == LEN_W'(PAT_LEN - 1));
  assign match_next = en && full && (window == PATTERN);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      if (match_next) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = window[PAT_LEN-2:0];
        if (!full) fill_d = fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_det_scheduler.sv
// seq_det_scheduler: shares one pattern detector between NUM_REQ byte-stream
// requesters, arbitrated round-robin per frame, and reports per-frame match
// counts over a valid/ready handshake.
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   req_valid/req_data/req_last/req_ready  per-requester byte stream
//                        (requester i owns req_data[8i+7:8i])
//   res_valid/res_ready  frame-result handshake
//   res_id, res_count    requester index and match count of the frame
//   busy                 FSM not in IDLE
module seq_det_scheduler
  import seq_det_pkg::*;
#(
  parameter int unsigned        NUM_REQ = 4,
  parameter int unsigned        PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
  parameter int unsigned        CNT_W   = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [$clog2(NUM_REQ)-1:0]  res_id,
  output logic [CNT_W-1:0]            res_count,
  output logic                        busy
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  sched_state_e      state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic              last_q, last_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              det_clr, det_en, det_match;
  logic [ID_W-1:0]   pick;
  logic              pick_found;
  logic              sel_valid, sel_last;
  logic [BYTE_W-1:0] sel_byte;

  pattern_det_core #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN)
  ) u_det (
    .clk        (clk),
    .reset      (reset),
    .clr        (det_clr),
    .en         (det_en),
    .bit_in     (byte_q[bit_idx_q]),
    .match_next (det_match)
  );

  // Round-robin pick: first valid requester after last_grant, with wrap.
  always_comb begin
    pick       = last_grant_q;
    pick_found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      int unsigned cand;
      cand = (int'(last_grant_q) + k) % NUM_REQ;
      if (!pick_found && req_valid[ID_W'(cand)]) begin
        pick_found = 1'b1;
        pick       = ID_W'(cand);
      end
    end
  end

  // Granted requester's stream and the ready fan-out.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_byte  = '0;
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_q) begin
        sel_valid    = req_valid[i];
        sel_last     = req_last[i];
        sel_byte     = req_data[i*BYTE_W +: BYTE_W];
        req_ready[i] = (state_q == LOAD);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    byte_d       = byte_q;
    last_d       = last_q;
    bit_idx_d    = bit_idx_q;
    count_d      = count_q;
    det_clr      = 1'b0;
    det_en       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick;
          det_clr = 1'b1;
          count_d = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (sel_valid) begin
          byte_d    = sel_byte;
          last_d    = sel_last;
          bit_idx_d = 3'd7;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        det_en = 1'b1;
        if (det_match && (count_q != '1)) count_d = count_q + 1'b1;
        if (bit_idx_q == 3'd0) state_d = last_q ? RESULT : LOAD;
        else                   bit_idx_d = bit_idx_q - 3'd1;
      end
      RESULT: begin
        if (res_ready) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      byte_q       <= '0;
      last_q       <= 1'b0;
      bit_idx_q    <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      byte_q       <= byte_d;
      last_q       <= last_d;
      bit_idx_q    <= bit_idx_d;
      count_q      <= count_d;
    end
  end

  assign res_valid = (state_q == RESULT);
  assign res_id    = grant_q;
  assign res_count = count_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_seq_det_scheduler.sv
module tb_seq_det_scheduler;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned CNT_W   = 8;

  typedef struct {
    int unsigned id;
    int unsigned cnt;
  } res_t;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [8*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_last = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 res_valid;
  logic                 res_ready = 1'b1;
  logic [1:0]           res_id;
  logic [CNT_W-1:0]     res_count;
  logic                 busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [8:0] rq[NUM_REQ][$];   // {last, data} per requester
  res_t       exp_q[$];
  res_t       obs_q[$];

  seq_det_scheduler #(
    .NUM_REQ (NUM_REQ),
    .PAT_LEN (4),
    .PATTERN (4'b1101),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_count (res_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Requester models: present queue heads, pop on accepted handshake.
  initial begin
    logic [NUM_REQ-1:0] acc;
    logic [8:0] h;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          h = rq[i][0];
          req_valid[i]        = 1'b1;
          req_data[8*i +: 8]  = h[7:0];
          req_last[i]         = h[8];
        end else begin
          req_valid[i]        = 1'b0;
          req_data[8*i +: 8]  = 8'h00;
          req_last[i]         = 1'b0;
        end
      end
    end
  end

  // Result monitor: capture each completed handshake.
  initial begin
    res_t r;
    forever begin
      @(negedge clk);
      if (!reset && res_valid && res_ready) begin
        r.id  = res_id;
        r.cnt = res_count;
        obs_q.push_back(r);
      end
    end
  end

  // Greedy leftmost scan; for a fixed-length pattern this equals the
  // non-overlapping detector's count.
  function automatic int unsigned model_count(input int unsigned n,
                                              input logic [7:0] b0, b1, b2);
    logic [23:0] v;
    int unsigned nb, i, cnt;
    logic [3:0] w;
    v = {b0, b1, b2};
    nb = 8 * n;
    i = 0;
    cnt = 0;
    while (i + 4 <= nb) begin
      w = {v[23-i], v[22-i], v[21-i], v[20-i]};
      if (w == 4'b1101) begin
        cnt++;
        i += 4;
      end else begin
        i++;
      end
    end
    return cnt;
  endfunction

  task automatic send_frame(input int unsigned req, input int unsigned n,
                            input logic [7:0] b0, b1, b2,
                            input int unsigned exp_cnt, input bit push_exp);
    logic [7:0] bs[3];
    res_t e;
    bs[0] = b0; bs[1] = b1; bs[2] = b2;
    for (int unsigned k = 0; k < n; k++)
      rq[req].push_back({(k == n - 1), bs[k]});
    if (push_exp) begin
      e.id  = req;
      e.cnt = exp_cnt;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_results(input int unsigned n);
    int unsigned cyc = 0;
    res_t e, o;
    while (obs_q.size() < n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (obs_q.size() < n) begin
      errors++;
      $display("FAIL result_timeout got %0d results, required %0d", obs_q.size(), n);
      exp_q.delete();
      obs_q.delete();
    end else begin
      for (int unsigned k = 0; k < n; k++) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result id %0d count %0d", obs_q[0].id, obs_q[0].cnt);
          void'(obs_q.pop_front());
        end else begin
          e = exp_q.pop_front();
          o = obs_q.pop_front();
          checks++;
          if (o.id !== e.id) begin
            errors++;
            $display("FAIL res_id got %0d required %0d", o.id, e.id);
          end
          checks++;
          if (o.cnt !== e.cnt) begin
            errors++;
            $display("FAIL res_count(id %0d) got %0d required %0d", e.id, o.cnt, e.cnt);
          end
        end
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({req_ready, res_valid, res_id, res_count, busy} !== '0) begin
      errors++;
      $display("FAIL %s outputs ready=%b valid=%b id=%0d count=%0d busy=%b required all zero",
               tag, req_ready, res_valid, res_id, res_count, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle_after_reset");
  endtask

  task automatic test_round_robin();
    @(negedge clk);
    send_frame(0, 1, 8'hD0, 8'h00, 8'h00, 1, 1'b1);
    send_frame(0, 1, 8'hDB, 8'h00, 8'h00, 1, 1'b0);
    send_frame(1, 1, 8'h00, 8'h00, 8'h00, 0, 1'b1);
    send_frame(2, 1, 8'hDD, 8'h00, 8'h00, 2, 1'b1);
    send_frame(3, 1, 8'h0D, 8'h00, 8'h00, 1, 1'b1);
    exp_q.push_back('{id: 0, cnt: 1});
    wait_results(5);
  endtask

  task automatic test_arb_skip();
    @(negedge clk);
    send_frame(2, 1, 8'hDD, 8'h00, 8'h00, 2, 1'b1);
    send_frame(0, 1, 8'hD0, 8'h00, 8'h00, 1, 1'b1);
    send_frame(2, 1, 8'h0D, 8'h00, 8'h00, 1, 1'b0);
    exp_q.push_back('{id: 2, cnt: 1});
    wait_results(3);
  endtask

  task automatic test_single_byte();
    int unsigned cyc = 0;
    @(negedge clk);
    send_frame(0, 1, 8'hD0, 8'h00, 8'h00, 1, 1'b1);
    @(posedge clk);
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (!res_valid && cyc < 40);
    checks++;
    if (cyc != 10) begin
      errors++;
      $display("FAIL latency got %0d cycles required 10", cyc);
    end
    wait_results(1);
  endtask

  task automatic test_non_overlap();
    @(negedge clk);
    send_frame(0, 1, 8'hDD, 8'h00, 8'h00, 2, 1'b1);
    send_frame(0, 1, 8'hDB, 8'h00, 8'h00, 1, 1'b1);
    wait_results(2);
  endtask

  task automatic test_span();
    @(negedge clk);
    send_frame(1, 2, 8'h01, 8'hA0, 8'h00, 1, 1'b1);
    send_frame(1, 1, 8'h03, 8'h00, 8'h00, 0, 1'b1);
    send_frame(1, 1, 8'h40, 8'h00, 8'h00, 0, 1'b1);
    wait_results(3);
  endtask

  task automatic test_backpressure();
    int unsigned cyc = 0;
    @(negedge clk);
    res_ready = 1'b0;
    send_frame(2, 1, 8'hD0, 8'h00, 8'h00, 1, 1'b1);
    send_frame(3, 1, 8'h00, 8'h00, 8'h00, 0, 1'b1);
    while (!res_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_id !== 2'd2 || res_count !== 8'd1 || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL stall_hold valid=%b id=%0d count=%0d ready=%b required 1/2/1/0000",
                 res_valid, res_id, res_count, req_ready);
      end
    end
    @(posedge clk);
    #1 res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL release_to_idle valid=%b busy=%b required 0/0", res_valid, busy);
    end
    wait_results(2);
  endtask

  task automatic test_mid_reset();
    int unsigned cyc = 0;
    @(negedge clk);
    send_frame(0, 2, 8'hDD, 8'hDD, 8'h00, 4, 1'b0);
    while (!req_ready[0] && cyc < 50) begin @(negedge clk); cyc++; end
    while (req_ready[0] && cyc < 100) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc >= 100 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reach_shift cycles %0d busy=%b required busy in SHIFT", cyc, busy);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rq[0].delete();
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("mid_frame_reset");
    repeat (20) @(negedge clk);
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL aborted_frame got %0d results required 0", obs_q.size());
      obs_q.delete();
    end
    send_frame(1, 1, 8'hD0, 8'h00, 8'h00, 1, 1'b0);
    send_frame(0, 1, 8'h0D, 8'h00, 8'h00, 1, 1'b1);
    exp_q.push_back('{id: 1, cnt: 1});
    wait_results(2);
  endtask

  task automatic test_random();
    int unsigned req, n;
    logic [7:0] b[3];
    logic [7:0] pool[4];
    pool[0] = 8'hDD; pool[1] = 8'hDB; pool[2] = 8'h6B; pool[3] = 8'h1A;
    for (int f = 0; f < 8; f++) begin
      req = $urandom_range(NUM_REQ - 1, 0);
      n   = $urandom_range(3, 1);
      for (int k = 0; k < 3; k++)
        b[k] = ($urandom_range(1, 0) != 0) ? pool[$urandom_range(3, 0)] : 8'($urandom);
      @(negedge clk);
      send_frame(req, n, b[0], b[1], b[2], model_count(n, b[0], b[1], b[2]), 1'b1);
      wait_results(1);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_arb_skip();
    test_single_byte();
    test_non_overlap();
    test_span();
    test_backpressure();
    test_mid_reset();
    test_random();
    repeat (20) @(negedge clk);
    checks++;
    if (obs_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover observed %0d expected %0d required 0/0", obs_q.size(), exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
